// File: rtl/rx_ctrl.sv
// Receiver handshake controller: captures completed frames into a small byte FIFO,
// counts framing errors and flags overflow. Capture-to-output latency is two edges.
module rx_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_READY,
  input  logic                     RX_ERROR,
  input  logic                     RX_BUSY,
  output logic                     DATA_ACK,
  output logic [7:0]               OUT_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READ,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [7:0]               ERR_CNT,
  output logic                     OVERFLOW,
  input  logic                     CLR_STAT
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            ack_q, ack_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];

  logic capture, push, pop;
  logic unused_busy;

  assign unused_busy = RX_BUSY;

  assign capture = (state_q == CAPTURE);
  assign pop     = OUT_READ && (level_q != '0);
  // A full FIFO still takes the byte when a pop frees a slot on the same edge.
  assign push    = capture && !RX_ERROR && ((level_q != DEPTH_L) || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (EN && RX_READY) state_d = CAPTURE;
      CAPTURE: state_d = ACK;
      ACK:     if (!RX_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == ACK);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = RX_DATA;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Clearing status takes priority over any event landing on the same edge.
  always_comb begin
    err_cnt_d = err_cnt_q;
    ovf_d     = ovf_q;
    if (CLR_STAT) begin
      err_cnt_d = 8'd0;
      ovf_d     = 1'b0;
    end else begin
      if (capture && RX_ERROR && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      if (capture && !RX_ERROR && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err_cnt_q <= 8'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign DATA_ACK  = ack_q;
  assign OUT_DATA  = mem_q[rd_ptr_q];
  assign OUT_VALID = (level_q != '0);
  assign LEVEL     = level_q;
  assign ERR_CNT   = err_cnt_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed bench for rx_ctrl (DEPTH=4): handshake timing, error counting, FIFO full/overflow, EN gating, reset mid-ACK.
module tb_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_READY = 1'b0;
  logic       RX_ERROR = 1'b0;
  logic       RX_BUSY = 1'b0;
  logic       DATA_ACK;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READ = 1'b0;
  logic [2:0] LEVEL;
  logic [7:0] ERR_CNT;
  logic       OVERFLOW;
  logic       CLR_STAT = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  rx_ctrl #(.DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
    .RX_ERROR(RX_ERROR), .RX_BUSY(RX_BUSY), .DATA_ACK(DATA_ACK), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READ(OUT_READ), .LEVEL(LEVEL), .ERR_CNT(ERR_CNT),
    .OVERFLOW(OVERFLOW), .CLR_STAT(CLR_STAT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full handshake: request, capture edge, ack edge, then release.
  task automatic frame(input logic [7:0] d, input logic e);
    RX_DATA  = d;
    RX_ERROR = e;
    RX_BUSY  = 1'b1;
    RX_READY = 1'b1;
    tick();
    tick();
    RX_READY = 1'b0;
    RX_ERROR = 1'b0;
    RX_BUSY  = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    OUT_READ = 1'b1;
    tick();
    OUT_READ = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_ack", 8'(DATA_ACK), 8'd0);
    chk("rst_valid", 8'(OUT_VALID), 8'd0);
    chk("rst_level", 8'(LEVEL), 8'd0);
    chk("rst_errcnt", ERR_CNT, 8'd0);
    chk("rst_ovf", 8'(OVERFLOW), 8'd0);

    // Good byte A5: ack and data appear on the second edge
    RST = 1'b0;
    EN = 1'b1;
    RX_DATA = 8'hA5;
    RX_READY = 1'b1;
    tick();
    chk("a5_edge1_ack", 8'(DATA_ACK), 8'd0);
    chk("a5_edge1_valid", 8'(OUT_VALID), 8'd0);
    tick();
    chk("a5_edge2_ack", 8'(DATA_ACK), 8'd1);
    chk("a5_edge2_valid", 8'(OUT_VALID), 8'd1);
    chk("a5_edge2_data", OUT_DATA, 8'hA5);
    chk("a5_edge2_level", 8'(LEVEL), 8'd1);
    tick();
    chk("a5_ack_held", 8'(DATA_ACK), 8'd1);
    chk("a5_level_held", 8'(LEVEL), 8'd1);
    RX_READY = 1'b0;
    tick();
    chk("a5_ack_drop", 8'(DATA_ACK), 8'd0);

    // Errored frame: counted, not stored, still acknowledged
    RX_DATA = 8'h3C;
    RX_ERROR = 1'b1;
    RX_READY = 1'b1;
    tick();
    tick();
    chk("err_ack", 8'(DATA_ACK), 8'd1);
    chk("err_cnt1", ERR_CNT, 8'd1);
    chk("err_level", 8'(LEVEL), 8'd1);
    RX_READY = 1'b0;
    RX_ERROR = 1'b0;
    tick();

    // 255 more errored frames -> counter saturates at 255
    for (int i = 0; i < 254; i++) frame(8'h3C, 1'b1);
    chk("err_cnt255", ERR_CNT, 8'd255);
    frame(8'h3C, 1'b1);
    chk("err_cnt_sat", ERR_CNT, 8'd255);

    // CLR_STAT clears counter, leaves FIFO alone
    CLR_STAT = 1'b1;
    tick();
    CLR_STAT = 1'b0;
    chk("clr_errcnt", ERR_CNT, 8'd0);
    chk("clr_level", 8'(LEVEL), 8'd1);
    chk("clr_data", OUT_DATA, 8'hA5);

    // Drain, then pop while empty is ignored
    pop_one();
    chk("drain_level", 8'(LEVEL), 8'd0);
    chk("drain_valid", 8'(OUT_VALID), 8'd0);
    pop_one();
    chk("empty_pop_level", 8'(LEVEL), 8'd0);

    // Five bytes into a 4-deep FIFO -> overflow, 05 lost
    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0);
    chk("full_level", 8'(LEVEL), 8'd4);
    chk("full_ovf", 8'(OVERFLOW), 8'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("full_read", OUT_DATA, 8'(i));
      pop_one();
    end
    chk("full_drained", 8'(OUT_VALID), 8'd0);
    chk("ovf_sticky", 8'(OVERFLOW), 8'd1);

    // CLR_STAT coincident with an overflowing capture: clear wins
    for (int i = 0; i < 4; i++) frame(8'h11 + 8'(i), 1'b0);
    RX_DATA = 8'h99;
    RX_READY = 1'b1;
    tick();
    CLR_STAT = 1'b1;
    tick();
    CLR_STAT = 1'b0;
    RX_READY = 1'b0;
    tick();
    chk("clr_wins_ovf", 8'(OVERFLOW), 8'd0);
    chk("clr_wins_level", 8'(LEVEL), 8'd4);

    // Full FIFO, capture coincident with a pop -> accepted
    RX_DATA = 8'h15;
    RX_READY = 1'b1;
    tick();
    OUT_READ = 1'b1;
    tick();
    OUT_READ = 1'b0;
    chk("pushpop_level", 8'(LEVEL), 8'd4);
    chk("pushpop_ovf", 8'(OVERFLOW), 8'd0);
    chk("pushpop_head", OUT_DATA, 8'h12);
    RX_READY = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) begin
      chk("pushpop_read", OUT_DATA, 8'h10 + 8'(i));
      pop_one();
    end
    chk("pushpop_drained", 8'(LEVEL), 8'd0);

    // EN=0 blocks capture for 20 cycles
    EN = 1'b0;
    RX_DATA = 8'h77;
    RX_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("en0_ack", 8'(DATA_ACK), 8'd0);
    end
    chk("en0_level", 8'(LEVEL), 8'd0);
    EN = 1'b1;
    tick();
    tick();
    chk("en1_ack", 8'(DATA_ACK), 8'd1);
    chk("en1_level", 8'(LEVEL), 8'd1);
    chk("en1_data", OUT_DATA, 8'h77);
    EN = 1'b0;
    tick();
    chk("en0_ack_holds", 8'(DATA_ACK), 8'd1);
    RX_READY = 1'b0;
    tick();
    chk("en0_ack_release", 8'(DATA_ACK), 8'd0);
    pop_one();
    EN = 1'b1;

    // Reset in ACK with RX_READY held -> same byte recaptured
    frame(8'h3C, 1'b1);
    chk("pre_rst_errcnt", ERR_CNT, 8'd1);
    RX_DATA = 8'h9A;
    RX_READY = 1'b1;
    tick();
    tick();
    chk("pre_rst_ack", 8'(DATA_ACK), 8'd1);
    chk("pre_rst_level", 8'(LEVEL), 8'd1);
    RST = 1'b1;
    tick();
    chk("rst_ack_ack", 8'(DATA_ACK), 8'd0);
    chk("rst_ack_level", 8'(LEVEL), 8'd0);
    chk("rst_ack_errcnt", ERR_CNT, 8'd0);
    tick();
    chk("rst_hold_ack", 8'(DATA_ACK), 8'd0);
    chk("rst_hold_valid", 8'(OUT_VALID), 8'd0);
    RST = 1'b0;
    tick();
    chk("recap_edge1_ack", 8'(DATA_ACK), 8'd0);
    tick();
    chk("recap_ack", 8'(DATA_ACK), 8'd1);
    chk("recap_level", 8'(LEVEL), 8'd1);
    chk("recap_data", OUT_DATA, 8'h9A);
    RX_READY = 1'b0;
    tick();
    chk("recap_release", 8'(DATA_ACK), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
